// File: rtl/fifo_uart_pkg.sv
// Shared types and constants for the FIFO-fed UART transmitter.
// Holds the frame state encoding, parity selectors and counter sizing helper.
package fifo_uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_e;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_PRESCALE_W = 16;

    // A single-bit word still needs a one-bit counter
    function automatic int bit_cnt_width(input int dw);
        return (dw > 1) ? $clog2(dw) : 1;
    endfunction

    localparam int BIT_CNT_W = bit_cnt_width(DEF_DATA_WIDTH);

endpackage

// File: rtl/fifo_uart_tx_if.sv
// First-word-fall-through FIFO read port shared by the FIFO and its consumer.
// The consumer (master) issues pops; the FIFO (slave) presents flag and data.
interface fifo_uart_tx_if
    import fifo_uart_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) ();

    logic                  EMPTY;
    logic [DATA_WIDTH-1:0] RD_DATA;
    logic                  R_INC;

    modport master (input EMPTY, input RD_DATA, output R_INC);
    modport slave  (output EMPTY, output RD_DATA, input R_INC);

endinterface

// File: rtl/uart_baud_cnt.sv
// Down-counter that times one UART bit; bit_end marks the final cycle of a bit.
// The owner reloads it with (clocks-per-bit - 1) on entry to every bit.
module uart_baud_cnt
    import fifo_uart_pkg::*;
#(
    parameter int PRESCALE_W = DEF_PRESCALE_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [PRESCALE_W-1:0] load_val,
    output logic                  bit_end
);

    logic [PRESCALE_W-1:0] cnt_r;

    // Reload on bit entry, otherwise count down and park at zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= {PRESCALE_W{1'b0}};
        end else if (load) begin
            cnt_r <= load_val;
        end else if (cnt_r != {PRESCALE_W{1'b0}}) begin
            cnt_r <= cnt_r - PRESCALE_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign bit_end = (cnt_r == {PRESCALE_W{1'b0}});

endmodule

// File: rtl/fifo_uart_tx.sv
// Pops words from a FWFT FIFO and serialises each as a UART frame:
// start bit, data LSB first, optional parity, one stop bit; back-to-back when data waits.
module fifo_uart_tx
    import fifo_uart_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int PRESCALE_W = DEF_PRESCALE_W
) (
    input  logic                  R_CLK,
    input  logic                  R_RST,
    fifo_uart_tx_if.master        rd,
    input  logic [PRESCALE_W-1:0] PRESCALE,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic                  TX_OUT,
    output logic                  BUSY
);

    localparam int BCW = bit_cnt_width(DATA_WIDTH);

    tx_state_e             state_r, state_nxt_s;
    logic [DATA_WIDTH-1:0] shift_r, shift_nxt_s;
    logic [BCW-1:0]        bit_cnt_r, bit_cnt_nxt_s;
    logic                  par_en_r, par_en_nxt_s;
    logic                  par_bit_r, par_bit_nxt_s;
    logic [PRESCALE_W-1:0] presc_m1_r, presc_m1_nxt_s;
    logic                  tx_out_r, tx_nxt_s;
    logic                  busy_r;
    logic                  pop_req_s, pop_s, inc_s, load_s, bit_end_s;

    function automatic logic calc_parity(input logic [DATA_WIDTH-1:0] d, input logic typ);
        return (typ == PAR_ODD) ? ~(^d) : (^d);
    endfunction

    uart_baud_cnt #(.PRESCALE_W(PRESCALE_W)) u_baud (
        .clk      (R_CLK),
        .rst_n    (R_RST),
        .load     (load_s),
        .load_val (presc_m1_nxt_s),
        .bit_end  (bit_end_s)
    );

    // Pops are suppressed while reset is held so no word is dropped silently
    assign pop_req_s = ~rd.EMPTY & R_RST;

    // Frame sequencing, pop decision and next-cycle line level
    always_comb begin
        state_nxt_s    = state_r;
        shift_nxt_s    = shift_r;
        bit_cnt_nxt_s  = bit_cnt_r;
        par_en_nxt_s   = par_en_r;
        par_bit_nxt_s  = par_bit_r;
        presc_m1_nxt_s = presc_m1_r;
        pop_s          = 1'b0;
        load_s         = 1'b0;
        inc_s          = 1'b0;
        tx_nxt_s       = 1'b1;

        case (state_r)
            IDLE: begin
                if (pop_req_s) pop_s = 1'b1;
                else           pop_s = 1'b0;
            end
            START: begin
                if (bit_end_s) begin
                    state_nxt_s   = DATA;
                    bit_cnt_nxt_s = {BCW{1'b0}};
                    load_s        = 1'b1;
                end else begin
                    state_nxt_s = START;
                end
            end
            DATA: begin
                if (bit_end_s) begin
                    shift_nxt_s = shift_r >> 1;
                    load_s      = 1'b1;
                    if (bit_cnt_r == BCW'(DATA_WIDTH - 1)) begin
                        state_nxt_s = par_en_r ? PARITY : STOP;
                    end else begin
                        bit_cnt_nxt_s = bit_cnt_r + BCW'(1);
                    end
                end else begin
                    state_nxt_s = DATA;
                end
            end
            PARITY: begin
                if (bit_end_s) begin
                    state_nxt_s = STOP;
                    load_s      = 1'b1;
                end else begin
                    state_nxt_s = PARITY;
                end
            end
            STOP: begin
                if (bit_end_s) begin
                    if (pop_req_s) pop_s = 1'b1;
                    else           state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = STOP;
                end
            end
            default: state_nxt_s = IDLE;
        endcase

        // A pop latches word and config together; a zero divider runs one clock per bit
        if (pop_s) begin
            inc_s          = 1'b1;
            load_s         = 1'b1;
            state_nxt_s    = START;
            shift_nxt_s    = rd.RD_DATA;
            par_en_nxt_s   = PAR_EN;
            par_bit_nxt_s  = calc_parity(rd.RD_DATA, PAR_TYP);
            presc_m1_nxt_s = (PRESCALE == {PRESCALE_W{1'b0}}) ? {PRESCALE_W{1'b0}}
                                                              : PRESCALE - PRESCALE_W'(1);
        end else begin
            inc_s = 1'b0;
        end

        case (state_nxt_s)
            START:   tx_nxt_s = 1'b0;
            DATA:    tx_nxt_s = shift_nxt_s[0];
            PARITY:  tx_nxt_s = par_bit_nxt_s;
            default: tx_nxt_s = 1'b1;
        endcase
    end

    // State, datapath and registered line outputs
    always_ff @(posedge R_CLK or negedge R_RST) begin
        if (!R_RST) begin
            state_r    <= IDLE;
            shift_r    <= {DATA_WIDTH{1'b0}};
            bit_cnt_r  <= {BCW{1'b0}};
            par_en_r   <= 1'b0;
            par_bit_r  <= 1'b0;
            presc_m1_r <= {PRESCALE_W{1'b0}};
            tx_out_r   <= 1'b1;
            busy_r     <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            shift_r    <= shift_nxt_s;
            bit_cnt_r  <= bit_cnt_nxt_s;
            par_en_r   <= par_en_nxt_s;
            par_bit_r  <= par_bit_nxt_s;
            presc_m1_r <= presc_m1_nxt_s;
            tx_out_r   <= tx_nxt_s;
            busy_r     <= (state_nxt_s != IDLE);
        end
    end

    assign rd.R_INC = inc_s;
    assign TX_OUT   = tx_out_r;
    assign BUSY     = busy_r;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Self-checking bench for fifo_uart_tx: a FIFO model feeds words, a scoreboard queue
// holds each word's expected frame and a negedge monitor checks the serial line bit by bit.
module tb_fifo_uart_tx;
    import fifo_uart_pkg::*;

    typedef struct {
        logic [7:0] data;
        int         p;
        logic       pe;
        logic       pt;
    } rec_t;

    typedef struct {
        logic [7:0] data;
        int         p;
        logic       pe;
        logic       pt;
        int         len;
        logic       par;
    } vec_t;

    logic        R_CLK = 1'b0;
    logic        R_RST;
    logic [15:0] PRESCALE;
    logic        PAR_EN;
    logic        PAR_TYP;
    logic        TX_OUT;
    logic        BUSY;

    fifo_uart_tx_if #(.DATA_WIDTH(8)) rif ();

    fifo_uart_tx #(.DATA_WIDTH(8), .PRESCALE_W(16)) dut (
        .R_CLK    (R_CLK),
        .R_RST    (R_RST),
        .rd       (rif),
        .PRESCALE (PRESCALE),
        .PAR_EN   (PAR_EN),
        .PAR_TYP  (PAR_TYP),
        .TX_OUT   (TX_OUT),
        .BUSY     (BUSY)
    );

    always #5 R_CLK = ~R_CLK;

    logic [7:0] mem [0:63];
    int   wr_ptr = 0;
    int   rd_ptr = 0;
    rec_t exp_q [$];
    int   tests = 0, fails = 0;
    int   cyc = 0, pop_cnt = 0, frames_done = 0;
    int   pop_cyc [0:63];
    int   mon_cyc, mon_p, mon_n, busy_run = 0, last_busy_len = 0;
    logic mon_active = 1'b0;
    rec_t cur;
    logic obs_par;
    vec_t vecs [6];

    assign rif.EMPTY   = (wr_ptr == rd_ptr);
    assign rif.RD_DATA = mem[rd_ptr % 64];

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic frame_bit(input rec_t r, input int idx);
        if (idx == 0) return 1'b0;
        if (idx <= 8) return r.data[idx-1];
        if (idx == 9 && r.pe) return (^r.data) ^ r.pt;
        return 1'b1;
    endfunction

    task automatic tick();
        @(posedge R_CLK);
        #1;
    endtask

    task automatic push_word(input logic [7:0] d, input int p, input logic pe, input logic pt);
        rec_t r;
        r.data = d; r.p = p; r.pe = pe; r.pt = pt;
        mem[wr_ptr % 64] = d;
        wr_ptr++;
        exp_q.push_back(r);
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n;
        n = 0;
        do begin
            @(negedge R_CLK);
            #2;
            n++;
        end while (!(rif.EMPTY && !BUSY && !mon_active) && n < budget);
        check({name, "_timeout"}, (n < budget) ? 1 : 0, 1);
    endtask

    task automatic wait_pops(input string name, input int target, input int budget);
        int n;
        n = 0;
        while (pop_cnt < target && n < budget) begin
            @(negedge R_CLK);
            #2;
            n++;
        end
        check({name, "_pop_timeout"}, (n < budget) ? 1 : 0, 1);
    endtask

    // The FIFO advances its read pointer just after the edge where the DUT took the word
    task automatic fifo_reader();
        forever begin
            @(posedge R_CLK);
            #1;
            rd_ptr = pop_cnt;
        end
    endtask

    task automatic monitor();
        forever begin
            @(negedge R_CLK);
            cyc++;
            if (!R_RST) begin
                mon_active = 1'b0;
                busy_run   = 0;
                check("rst_tx", TX_OUT, 1);
                check("rst_busy", BUSY, 0);
                check("rst_rinc", rif.R_INC, 0);
            end else begin
                if (rif.R_INC && rif.EMPTY) check("rinc_when_empty", 1, 0);
                if (mon_active) begin
                    check("tx_bit", TX_OUT, frame_bit(cur, mon_cyc / mon_p));
                    check("busy_in_frame", BUSY, 1);
                    if (cur.pe && (mon_cyc / mon_p) == 9) obs_par = TX_OUT;
                    mon_cyc++;
                    if (mon_cyc == mon_n * mon_p) begin
                        mon_active = 1'b0;
                        frames_done++;
                    end
                end else begin
                    check("idle_tx", TX_OUT, 1);
                    check("idle_busy", BUSY, 0);
                end
                if (rif.R_INC) begin
                    pop_cyc[pop_cnt % 64] = cyc;
                    pop_cnt++;
                    if (exp_q.size() == 0) begin
                        check("unexpected_pop", 1, 0);
                    end else begin
                        cur        = exp_q.pop_front();
                        mon_p      = (cur.p == 0) ? 1 : cur.p;
                        mon_n      = 10 + (cur.pe ? 1 : 0);
                        mon_cyc    = 0;
                        mon_active = 1'b1;
                    end
                end
                if (BUSY) begin
                    busy_run++;
                end else if (busy_run != 0) begin
                    last_busy_len = busy_run;
                    busy_run      = 0;
                end
            end
        end
    endtask

    initial begin
        int base;
        vecs[0] = '{8'hA5, 4, 1'b0, 1'b0, 40, 1'b0};
        vecs[1] = '{8'h07, 2, 1'b1, 1'b0, 22, 1'b1};
        vecs[2] = '{8'h07, 2, 1'b1, 1'b1, 22, 1'b0};
        vecs[3] = '{8'h00, 0, 1'b0, 1'b0, 10, 1'b0};
        vecs[4] = '{8'hFF, 1, 1'b1, 1'b1, 11, 1'b1};
        vecs[5] = '{8'h3C, 3, 1'b1, 1'b0, 33, 1'b0};

        R_RST = 1'b0; PRESCALE = 16'd2; PAR_EN = 1'b0; PAR_TYP = 1'b0;
        fork
            monitor();
            fifo_reader();
        join_none

        // Reset held with data waiting: no pop until release, then pop immediately
        push_word(8'h3C, 2, 1'b0, 1'b0);
        repeat (5) tick();
        check("rst_no_pop", pop_cnt, 0);
        R_RST = 1'b1;
        @(negedge R_CLK);
        #2;
        check("pop_after_release", pop_cnt, 1);
        wait_idle("reset_frame", 200);
        check("reset_frame_len", last_busy_len, 20);

        // Table of single-word frames
        for (int i = 0; i < 6; i++) begin
            tick();
            PRESCALE = 16'(vecs[i].p); PAR_EN = vecs[i].pe; PAR_TYP = vecs[i].pt;
            base    = pop_cnt;
            obs_par = 1'bx;
            push_word(vecs[i].data, vecs[i].p, vecs[i].pe, vecs[i].pt);
            wait_idle("vec", 500);
            check("vec_pops", pop_cnt - base, 1);
            check("vec_len", last_busy_len, vecs[i].len);
            if (vecs[i].pe) check("vec_parity", obs_par, vecs[i].par);
        end

        // Back-to-back frames: pops 30 cycles apart, BUSY never drops
        tick();
        PRESCALE = 16'd3; PAR_EN = 1'b0; PAR_TYP = 1'b0;
        base = pop_cnt;
        push_word(8'h01, 3, 1'b0, 1'b0);
        push_word(8'h02, 3, 1'b0, 1'b0);
        push_word(8'h03, 3, 1'b0, 1'b0);
        wait_idle("b2b", 500);
        check("b2b_pops", pop_cnt - base, 3);
        check("b2b_gap1", pop_cyc[(base + 1) % 64] - pop_cyc[base % 64], 30);
        check("b2b_gap2", pop_cyc[(base + 2) % 64] - pop_cyc[(base + 1) % 64], 30);
        check("b2b_busy_len", last_busy_len, 90);

        // Divider change mid-frame only affects the following frame
        tick();
        PRESCALE = 16'd4;
        base = pop_cnt;
        push_word(8'h55, 4, 1'b0, 1'b0);
        push_word(8'h66, 8, 1'b0, 1'b0);
        wait_pops("cfg", base + 1, 50);
        repeat (10) tick();
        PRESCALE = 16'd8;
        wait_idle("cfg", 500);
        check("cfg_gap", pop_cyc[(base + 1) % 64] - pop_cyc[base % 64], 40);
        check("cfg_busy_len", last_busy_len, 120);

        // Reset during data bit 3 (a zero bit) forces the line high at once
        tick();
        PRESCALE = 16'd4;
        base = pop_cnt;
        push_word(8'h37, 4, 1'b0, 1'b0);
        wait_pops("midrst", base + 1, 50);
        repeat (18) @(negedge R_CLK);
        #1;
        check("midrst_tx_before", TX_OUT, 0);
        R_RST = 1'b0;
        #1;
        check("midrst_tx_async", TX_OUT, 1);
        check("midrst_busy_async", BUSY, 0);
        base = frames_done;
        push_word(8'h81, 4, 1'b0, 1'b0);
        repeat (3) tick();
        R_RST = 1'b1;
        wait_idle("midrst", 300);
        check("midrst_frames", frames_done - base, 1);
        check("midrst_len", last_busy_len, 40);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
